// File: rtl/lenet_result_display_if.sv
// rtl/lenet_result_display_if.sv - result capture and display signal bundle
interface lenet_result_display_if #(
    parameter int OUTPUT_NODE = 10,
    parameter int DATA_SIZE   = 8
);
    logic                              lenet_finish;
    logic [DATA_SIZE*OUTPUT_NODE-1:0]  result;
    logic [4:0]                        graph;
    logic                              class_valid;
    logic [3:0]                        class_idx;
    logic [7:0]                        an;
    logic [7:0]                        a_to_g;

    modport master (
        output lenet_finish, result, graph,
        input  class_valid, class_idx, an, a_to_g
    );

    modport slave (
        input  lenet_finish, result, graph,
        output class_valid, class_idx, an, a_to_g
    );
endinterface

// File: rtl/lenet_result_display.sv
// rtl/lenet_result_display.sv - sequential signed argmax of LeNet scores with 8-digit seven-segment readout
module lenet_result_display #(
    parameter int OUTPUT_NODE = 10,
    parameter int DATA_SIZE   = 8,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                   clk,
    input  logic                   rst,
    lenet_result_display_if.slave  bus
);
    localparam int IDX_W = $clog2(OUTPUT_NODE + 1);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]                       state_q, state_d;
    logic [DATA_SIZE*OUTPUT_NODE-1:0] result_q, result_d;
    logic [4:0]                       graph_q, graph_d;
    logic [DATA_SIZE-1:0]             best_q, best_d;
    logic [3:0]                       best_idx_q, best_idx_d;
    logic [IDX_W-1:0]                 scan_idx_q, scan_idx_d;
    logic                             class_valid_q, class_valid_d;
    logic [3:0]                       class_idx_q, class_idx_d;
    logic [CNT_W-1:0]                 refresh_q, refresh_d;
    logic [2:0]                       digit_q, digit_d;
    logic [7:0]                       an_q, an_d;
    logic [7:0]                       a_to_g_q, a_to_g_d;
    logic [DATA_SIZE-1:0]             cur_score;

    function automatic logic [7:0] seg_enc(input logic [3:0] v);
        case (v)
            4'h0: seg_enc = 8'hC0;  4'h1: seg_enc = 8'hF9;
            4'h2: seg_enc = 8'hA4;  4'h3: seg_enc = 8'hB0;
            4'h4: seg_enc = 8'h99;  4'h5: seg_enc = 8'h92;
            4'h6: seg_enc = 8'h82;  4'h7: seg_enc = 8'hF8;
            4'h8: seg_enc = 8'h80;  4'h9: seg_enc = 8'h90;
            4'hA: seg_enc = 8'h88;  4'hB: seg_enc = 8'h83;
            4'hC: seg_enc = 8'hC6;  4'hD: seg_enc = 8'hA1;
            4'hE: seg_enc = 8'h86;  default: seg_enc = 8'h8E;
        endcase
    endfunction

    always_comb begin
        cur_score = '0;
        for (int k = 0; k < OUTPUT_NODE; k++) begin
            if (scan_idx_q == IDX_W'(k)) cur_score = result_q[k*DATA_SIZE +: DATA_SIZE];
        end

        state_d       = state_q;
        result_d      = result_q;
        graph_d       = graph_q;
        best_d        = best_q;
        best_idx_d    = best_idx_q;
        scan_idx_d    = scan_idx_q;
        class_valid_d = class_valid_q;
        class_idx_d   = class_idx_q;

        case (state_q)
            S_IDLE, S_HOLD: begin
                if (bus.lenet_finish) begin
                    result_d      = bus.result;
                    graph_d       = bus.graph;
                    best_d        = bus.result[DATA_SIZE-1:0];
                    best_idx_d    = 4'd0;
                    scan_idx_d    = IDX_W'(1);
                    class_valid_d = 1'b0;
                    state_d       = S_SCAN;
                end
            end
            S_SCAN: begin
                // finish pulses are deliberately not looked at here
                if (scan_idx_q == IDX_W'(OUTPUT_NODE)) begin
                    class_idx_d   = best_idx_q;
                    class_valid_d = 1'b1;
                    state_d       = S_HOLD;
                end else begin
                    if ($signed(cur_score) > $signed(best_q)) begin
                        best_d     = cur_score;
                        best_idx_d = 4'(scan_idx_q);
                    end
                    scan_idx_d = scan_idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (refresh_q == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            digit_d   = digit_q + 3'd1;
        end else begin
            refresh_d = refresh_q + 1'b1;
            digit_d   = digit_q;
        end

        an_d = ~(8'd1 << digit_q);
        case (digit_q)
            3'd0:    a_to_g_d = class_valid_q ? seg_enc(class_idx_q) : 8'hBF;
            3'd2:    a_to_g_d = seg_enc(graph_q[3:0]);
            3'd3:    a_to_g_d = seg_enc({3'b000, graph_q[4]});
            default: a_to_g_d = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            result_q      <= '0;
            graph_q       <= '0;
            best_q        <= '0;
            best_idx_q    <= '0;
            scan_idx_q    <= '0;
            class_valid_q <= 1'b0;
            class_idx_q   <= '0;
            refresh_q     <= '0;
            digit_q       <= '0;
            an_q          <= 8'hFF;
            a_to_g_q      <= 8'hFF;
        end else begin
            state_q       <= state_d;
            result_q      <= result_d;
            graph_q       <= graph_d;
            best_q        <= best_d;
            best_idx_q    <= best_idx_d;
            scan_idx_q    <= scan_idx_d;
            class_valid_q <= class_valid_d;
            class_idx_q   <= class_idx_d;
            refresh_q     <= refresh_d;
            digit_q       <= digit_d;
            an_q          <= an_d;
            a_to_g_q      <= a_to_g_d;
        end
    end

    assign bus.class_valid = class_valid_q;
    assign bus.class_idx   = class_idx_q;
    assign bus.an          = an_q;
    assign bus.a_to_g      = a_to_g_q;
endmodule

// File: tb/tb_lenet_result_display.sv
// tb/tb_lenet_result_display.sv - randomized self-checking bench for lenet_result_display
module tb_lenet_result_display;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc;

    always #5 clk = ~clk;

    lenet_result_display_if #(.OUTPUT_NODE(10), .DATA_SIZE(8)) bus ();

    lenet_result_display #(.OUTPUT_NODE(10), .DATA_SIZE(8), .REFRESH_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // edges since reset release; the display position follows from this alone
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int argmax(input logic [7:0] v [10]);
        int best = 0;
        for (int i = 1; i < 10; i++)
            if ($signed(v[i]) > $signed(v[best])) best = i;
        return best;
    endfunction

    task automatic check_disp(input bit valid, input int cls, input logic [4:0] g);
        int d;
        logic [7:0] an_exp, seg_exp;
        d = ((cyc - 1) / DIV) % 8;
        an_exp = ~(8'd1 << d);
        case (d)
            0:       seg_exp = valid ? seg_tab[cls] : 8'hBF;
            2:       seg_exp = seg_tab[g[3:0]];
            3:       seg_exp = seg_tab[{3'b000, g[4]}];
            default: seg_exp = 8'hFF;
        endcase
        check("an", bus.an, an_exp);
        check("a_to_g", bus.a_to_g, seg_exp);
    endtask

    task automatic drive_vec(input logic [7:0] v [10]);
        for (int i = 0; i < 10; i++) bus.result[i*8 +: 8] = v[i];
    endtask

    task automatic scramble();
        bus.result = {$urandom, $urandom, $urandom};
        bus.graph  = 5'($urandom);
    endtask

    task automatic run_image(input logic [7:0] v [10], input logic [4:0] g,
                             input bit mid, input int hold_cycles);
        int exp;
        exp = argmax(v);
        drive_vec(v);
        bus.graph = g;
        bus.lenet_finish = 1'b1;
        step();
        bus.lenet_finish = 1'b0;
        scramble();
        check("valid_at_capture", bus.class_valid, 0);
        for (int k = 1; k <= 10; k++) begin
            if (mid && k == 4) begin
                scramble();
                bus.lenet_finish = 1'b1;
            end
            step();
            bus.lenet_finish = 1'b0;
            check_disp(1'b0, 0, g);
            if (k < 10) begin
                check("valid_scan", bus.class_valid, 0);
            end else begin
                check("valid_done", bus.class_valid, 1);
                check("class_idx", bus.class_idx, exp);
            end
        end
        for (int h = 0; h < hold_cycles; h++) begin
            step();
            check_disp(1'b1, exp, g);
            check("class_idx_hold", bus.class_idx, exp);
            check("valid_hold", bus.class_valid, 1);
        end
    endtask

    task automatic reset_mid_scan(input logic [7:0] v [10], input logic [4:0] g);
        drive_vec(v);
        bus.graph = g;
        bus.lenet_finish = 1'b1;
        step();
        bus.lenet_finish = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        #1;
        check("rst_valid", bus.class_valid, 0);
        check("rst_idx", bus.class_idx, 0);
        check("rst_an", bus.an, 8'hFF);
        check("rst_seg", bus.a_to_g, 8'hFF);
        repeat (2) step();
        check("rst_valid_held", bus.class_valid, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [7:0] v [10];
    logic [4:0] g;

    initial begin
        rst = 1'b1;
        bus.lenet_finish = 1'b0;
        bus.result = '0;
        bus.graph = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", bus.class_valid, 0);
        check("reset_idx", bus.class_idx, 0);
        check("reset_an", bus.an, 8'hFF);
        check("reset_seg", bus.a_to_g, 8'hFF);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step();
            check_disp(1'b0, 0, 5'd0);
            check("idle_valid", bus.class_valid, 0);
        end

        v = '{8'd3, 8'd7, 8'hFE, 8'd12, 8'd5, 8'd0, 8'd1, 8'd9, 8'd4, 8'd11};
        run_image(v, 5'd4, 1'b0, 20);

        v = '{8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'hFB};
        run_image(v, 5'd9, 1'b0, 2);
        v = '{8'h80, 8'h80, 8'h7F, 8'h80, 8'h80, 8'h80, 8'h7F, 8'h80, 8'h80, 8'h80};
        run_image(v, 5'd10, 1'b0, 2);
        v = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'd1};
        run_image(v, 5'd31, 1'b0, 2);

        v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd50, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
        run_image(v, 5'd17, 1'b1, 4);

        reset_mid_scan(v, 5'd6);
        v = '{8'd0, 8'hF0, 8'd20, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd19};
        run_image(v, 5'd8, 1'b0, 4);

        v = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd100, 8'd0, 8'd0};
        run_image(v, 5'h13, 1'b0, 40);

        v = '{8'd5, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        run_image(v, 5'd1, 1'b0, 6);
        v = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd7, 8'd1, 8'd1, 8'd1};
        run_image(v, 5'd2, 1'b0, 36);

        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < 10; i++) v[i] = 8'($urandom);
            if (n % 3 == 0) v[$urandom_range(0, 9)] = v[$urandom_range(0, 9)];
            g = 5'($urandom);
            run_image(v, g, 1'($urandom), $urandom_range(0, 12));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
